// File: rtl/servant_spi_ram_slave_sync.sv
// SPI serial-RAM/FRAM slave emulator, fully in the i_clk domain.
// SCK/CS/MOSI are oversampled through synchronisers and drive a single-port synchronous RAM.
module servant_spi_ram_slave_sync #(
   parameter int unsigned  ADDR_W      = 18,
   parameter int unsigned  ADDR_BYTES  = 3,
   parameter int unsigned  SYNC_STAGES = 2,
   parameter logic [7:0]   ID_MFG      = 8'h04,
   parameter logic [7:0]   ID_CONT     = 8'h7F,
   parameter logic [15:0]  ID_PROD     = 16'h4803
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              spi_sck,
   input  logic              spi_cs,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rd_en,
   output logic              ram_wr_en,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata
);

   localparam logic [7:0] CMD_WRSR  = 8'h01;
   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRDI  = 8'h04;
   localparam logic [7:0] CMD_RDSR  = 8'h05;
   localparam logic [7:0] CMD_WREN  = 8'h06;
   localparam logic [7:0] CMD_FAST  = 8'h0B;
   localparam logic [7:0] CMD_RDID  = 8'h9F;
   localparam int unsigned CNT_W = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

   typedef enum logic [3:0] {
      ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA_WR,
      ST_DATA_RD, ST_STAT, ST_ID, ST_IGNORE
   } state_t;

   logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
   logic                   r_sck_d;
   logic                   w_sck, w_cs, w_mosi, w_rise, w_fall, w_byte_done;
   logic [7:0]             w_rx_byte;

   state_t            r_state;
   logic [7:0]        r_cmd;
   logic [2:0]        r_bit_cnt;
   logic [6:0]        r_rx_shift;
   logic [7:0]        r_tx_shift, r_tx_next;
   logic [CNT_W-1:0]  r_addr_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [2:0]        r_id_idx;
   logic [7:0]        r_status;
   logic              r_wel_set_pend, r_wel_clr_pend;
   logic              r_rd_en, r_rd_dly, r_wr_en;
   logic [7:0]        r_wdata;

   // NOTE: the CS chain resets to 1 so the slave comes out of reset deselected.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sck_sync  <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_sck_d     <= 1'b0;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         r_sck_d     <= w_sck;
      end
   end

   assign w_sck       = r_sck_sync[SYNC_STAGES-1];
   assign w_cs        = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
   assign w_rise      = w_sck & ~r_sck_d & ~w_cs;
   assign w_fall      = ~w_sck & r_sck_d & ~w_cs;
   assign w_rx_byte   = {r_rx_shift, w_mosi};
   assign w_byte_done = w_rise && (r_bit_cnt == 3'd7);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= ST_IDLE;
         r_cmd          <= 8'h00;
         r_bit_cnt      <= 3'd0;
         r_rx_shift     <= 7'd0;
         r_tx_shift     <= 8'h00;
         r_tx_next      <= 8'h00;
         r_addr_cnt     <= '0;
         r_addr         <= '0;
         r_id_idx       <= 3'd0;
         r_status       <= 8'h00;
         r_wel_set_pend <= 1'b0;
         r_wel_clr_pend <= 1'b0;
         r_rd_en        <= 1'b0;
         r_rd_dly       <= 1'b0;
         r_wr_en        <= 1'b0;
         r_wdata        <= 8'h00;
      end else begin
         r_rd_en  <= 1'b0;
         r_wr_en  <= 1'b0;
         r_rd_dly <= r_rd_en;
         // Read data lands one cycle after the strobe; capture it as the next TX byte.
         if (r_rd_dly) begin
            r_tx_next <= ram_rdata;
            r_addr    <= r_addr + ADDR_W'(1);
         end
         if (r_wr_en) r_addr <= r_addr + ADDR_W'(1);

         if (w_cs) begin
            r_state        <= ST_IDLE;
            r_bit_cnt      <= 3'd0;
            r_rx_shift     <= 7'd0;
            r_tx_shift     <= 8'h00;
            r_tx_next      <= 8'h00;
            r_rd_dly       <= 1'b0;
            r_wel_set_pend <= 1'b0;
            r_wel_clr_pend <= 1'b0;
            if (r_wel_clr_pend)      r_status[1] <= 1'b0;
            else if (r_wel_set_pend) r_status[1] <= 1'b1;
         end else begin
            if (r_state == ST_IDLE) r_state <= ST_CMD;
            if (w_fall)
               r_tx_shift <= (r_bit_cnt == 3'd0) ? r_tx_next : {r_tx_shift[6:0], 1'b0};
            if (w_rise) begin
               r_bit_cnt  <= r_bit_cnt + 3'd1;
               r_rx_shift <= w_rx_byte[6:0];
            end
            if (w_byte_done) begin
               case (r_state)
                  ST_IDLE, ST_CMD: begin
                     r_cmd <= w_rx_byte;
                     case (w_rx_byte)
                        CMD_WREN: begin r_wel_set_pend <= 1'b1; r_state <= ST_IGNORE; end
                        CMD_WRDI: begin r_wel_clr_pend <= 1'b1; r_state <= ST_IGNORE; end
                        CMD_RDSR: begin r_tx_next <= r_status; r_state <= ST_STAT; end
                        CMD_WRSR: r_state <= ST_DATA_WR;
                        CMD_WRITE, CMD_READ, CMD_FAST: begin
                           r_addr_cnt <= '0;
                           r_addr     <= '0;
                           r_state    <= ST_ADDR;
                        end
                        CMD_RDID: begin
                           r_tx_next <= ID_MFG;
                           r_id_idx  <= 3'd1;
                           r_state   <= ST_ID;
                        end
                        default: r_state <= ST_IGNORE;
                     endcase
                  end
                  ST_ADDR: begin
                     r_addr <= ADDR_W'({r_addr, w_rx_byte});
                     if (r_addr_cnt == CNT_W'(ADDR_BYTES - 1)) begin
                        if (r_cmd == CMD_WRITE)     r_state <= ST_DATA_WR;
                        else if (r_cmd == CMD_FAST) r_state <= ST_DUMMY;
                        else begin
                           r_rd_en <= 1'b1;
                           r_state <= ST_DATA_RD;
                        end
                     end else begin
                        r_addr_cnt <= r_addr_cnt + 1'b1;
                     end
                  end
                  ST_DUMMY: begin
                     r_rd_en <= 1'b1;
                     r_state <= ST_DATA_RD;
                  end
                  ST_DATA_RD: r_rd_en <= 1'b1;
                  ST_DATA_WR: begin
                     if (r_cmd == CMD_WRSR) begin
                        if (r_status[1]) r_status[7:2] <= w_rx_byte[7:2];
                        r_wel_clr_pend <= 1'b1;
                        r_state        <= ST_IGNORE;
                     end else if (r_status[1]) begin
                        r_wr_en        <= 1'b1;
                        r_wdata        <= w_rx_byte;
                        r_wel_clr_pend <= 1'b1;
                     end
                  end
                  ST_STAT: r_tx_next <= r_status;
                  ST_ID: begin
                     case (r_id_idx)
                        3'd1:    r_tx_next <= ID_CONT;
                        3'd2:    r_tx_next <= ID_PROD[15:8];
                        3'd3:    r_tx_next <= ID_PROD[7:0];
                        default: r_tx_next <= 8'h00;
                     endcase
                     if (r_id_idx != 3'd4) r_id_idx <= r_id_idx + 3'd1;
                  end
                  default: r_tx_next <= 8'h00;
               endcase
            end
         end
      end
   end

   assign spi_miso  = r_tx_shift[7];
   assign ram_addr  = r_addr;
   assign ram_rd_en = r_rd_en;
   assign ram_wr_en = r_wr_en;
   assign ram_wdata = r_wdata;

endmodule

// File: tb/tb_servant_spi_ram_slave_sync.sv
// Table-driven bench for servant_spi_ram_slave_sync: SPI mode-0 master plus a synchronous RAM model.
`timescale 1ns/1ps
module tb_servant_spi_ram_slave_sync;

   localparam int HALF = 50;
   localparam int NV   = 20;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        spi_sck = 1'b0;
   logic        spi_cs = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic [17:0] ram_addr;
   logic        ram_rd_en, ram_wr_en;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata = 8'h00;

   servant_spi_ram_slave_sync dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 i_clk = ~i_clk;

   // RAM model: initial content is addr[7:0] ^ 8'h3C.
   logic [7:0] mem [0:(1<<18)-1];
   bit         mem_init = 1'b0;
   always @(posedge i_clk) begin
      if (!mem_init) begin
         for (int a = 0; a < (1<<18); a++) mem[a] = 8'(a) ^ 8'h3C;
         mem_init = 1'b1;
      end else begin
         if (ram_rd_en) ram_rdata <= mem[ram_addr];
         if (ram_wr_en) mem[ram_addr] <= ram_wdata;
      end
   end

   int          wr_cnt = 0, rd_cnt = 0;
   logic [17:0] wr_log [0:255];
   logic [7:0]  wd_log [0:255];
   logic [17:0] rd_log [0:255];
   always @(negedge i_clk) begin
      if (ram_wr_en && wr_cnt < 256) begin
         wr_log[wr_cnt] = ram_addr;
         wd_log[wr_cnt] = ram_wdata;
         wr_cnt++;
      end
      if (ram_rd_en && rd_cnt < 256) begin
         rd_log[rd_cnt] = ram_addr;
         rd_cnt++;
      end
   end

   int n_checks = 0, n_errors = 0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
      r = 8'h00;
      for (int j = 0; j < nbits; j++) begin
         spi_mosi = b[7-j];
         #HALF;
         r[7-j] = spi_miso;
         spi_sck = 1'b1;
         #HALF;
         spi_sck = 1'b0;
      end
   endtask

   task automatic spi_xfer(input int n, input logic [63:0] m, output logic [63:0] got);
      logic [7:0] r;
      got = '0;
      @(negedge i_clk);
      spi_cs = 1'b0;
      #HALF;
      for (int k = 0; k < n; k++) begin
         spi_bits(m[8*(n-1-k) +: 8], 8, r);
         got[8*(n-1-k) +: 8] = r;
      end
      #HALF;
      spi_cs   = 1'b1;
      spi_mosi = 1'b0;
      repeat (12) @(negedge i_clk);
   endtask

   typedef struct {
      string       name;
      int          n;
      logic [63:0] mosi;
      logic [63:0] miso;
      logic [7:0]  chk;
      int          exp_wr;
      int          exp_rd;
      logic [17:0] a0;
      logic [17:0] a1;
      logic [7:0]  d0;
   } vec_t;

   vec_t vec [NV];

   initial begin
      logic [63:0] got;
      logic [7:0]  r;
      int          wr0, rd0;

      vec[0]  = '{"wren0",      1, 64'h06,                   64'h0,                    8'b0,       0, 0, 18'h0,     18'h0,     8'h00};
      vec[1]  = '{"write",      6, 64'h02_01_23_45_A5_5A,    64'h0,                    8'b0,       2, 0, 18'h12345, 18'h12346, 8'hA5};
      vec[2]  = '{"rdsr_clr",   3, 64'h05_00_00,             64'h00_00_00,             8'b110,     0, 0, 18'h0,     18'h0,     8'h00};
      vec[3]  = '{"read",       6, 64'h03_01_23_45_00_00,    64'h00_00_00_00_A5_5A,    8'b110000,  0, 3, 18'h12345, 18'h12346, 8'h00};
      vec[4]  = '{"write_nowel",5, 64'h02_00_00_10_FF,       64'h0,                    8'b0,       0, 0, 18'h0,     18'h0,     8'h00};
      vec[5]  = '{"read_orig",  5, 64'h03_00_00_10_00,       64'h00_00_00_00_2C,       8'b10000,   0, 2, 18'h10,    18'h11,    8'h00};
      vec[6]  = '{"rdid",       7, 64'h9F_00_00_00_00_00_00, 64'h00_04_7F_48_03_00_00, 8'b1111110, 0, 0, 18'h0,     18'h0,     8'h00};
      vec[7]  = '{"wren1",      1, 64'h06,                   64'h0,                    8'b0,       0, 0, 18'h0,     18'h0,     8'h00};
      vec[8]  = '{"rdsr_wel",   2, 64'h05_00,                64'h00_02,                8'b10,      0, 0, 18'h0,     18'h0,     8'h00};
      vec[9]  = '{"wrsr",       2, 64'h01_FC,                64'h0,                    8'b0,       0, 0, 18'h0,     18'h0,     8'h00};
      vec[10] = '{"rdsr_wrsr",  3, 64'h05_00_00,             64'h00_FC_FC,             8'b110,     0, 0, 18'h0,     18'h0,     8'h00};
      vec[11] = '{"wren2",      1, 64'h06,                   64'h0,                    8'b0,       0, 0, 18'h0,     18'h0,     8'h00};
      vec[12] = '{"rdsr_fe",    2, 64'h05_00,                64'h00_FE,                8'b10,      0, 0, 18'h0,     18'h0,     8'h00};
      vec[13] = '{"wrdi",       1, 64'h04,                   64'h0,                    8'b0,       0, 0, 18'h0,     18'h0,     8'h00};
      vec[14] = '{"rdsr_fc",    2, 64'h05_00,                64'h00_FC,                8'b10,      0, 0, 18'h0,     18'h0,     8'h00};
      vec[15] = '{"fast_wrap",  7, 64'h0B_03_FF_FF_00_00_00, 64'h00_00_00_00_00_C3_3C, 8'b1100000, 0, 3, 18'h3FFFF, 18'h00000, 8'h00};
      vec[16] = '{"ignore",     3, 64'hAA_00_00,             64'h00_00_00,             8'b110,     0, 0, 18'h0,     18'h0,     8'h00};
      vec[17] = '{"wren3",      1, 64'h06,                   64'h0,                    8'b0,       0, 0, 18'h0,     18'h0,     8'h00};
      vec[18] = '{"write_wrap", 6, 64'h02_FF_FF_FF_11_22,    64'h0,                    8'b0,       2, 0, 18'h3FFFF, 18'h00000, 8'h11};
      vec[19] = '{"read_wrap",  6, 64'h03_03_FF_FF_00_00,    64'h00_00_00_00_11_22,    8'b110000,  0, 3, 18'h3FFFF, 18'h00000, 8'h00};

      // Reset state.
      repeat (4) @(negedge i_clk);
      i_rst_n = 1'b1;
      repeat (4) @(negedge i_clk);
      check("rst_miso",  32'(spi_miso),  32'h0);
      check("rst_addr",  32'(ram_addr),  32'h0);
      check("rst_rd_en", 32'(ram_rd_en), 32'h0);
      check("rst_wr_en", 32'(ram_wr_en), 32'h0);
      check("rst_wdata", 32'(ram_wdata), 32'h0);

      for (int i = 0; i < NV; i++) begin
         wr0 = wr_cnt;
         rd0 = rd_cnt;
         spi_xfer(vec[i].n, vec[i].mosi, got);
         for (int k = 0; k < vec[i].n; k++)
            if (vec[i].chk[k])
               check($sformatf("%s.byte%0d", vec[i].name, k),
                     32'(got[8*(vec[i].n-1-k) +: 8]), 32'(vec[i].miso[8*(vec[i].n-1-k) +: 8]));
         check($sformatf("%s.n_wr", vec[i].name), wr_cnt - wr0, vec[i].exp_wr);
         check($sformatf("%s.n_rd", vec[i].name), rd_cnt - rd0, vec[i].exp_rd);
         if (vec[i].exp_wr >= 1) begin
            check($sformatf("%s.wr_a0", vec[i].name), 32'(wr_log[wr0]), 32'(vec[i].a0));
            check($sformatf("%s.wr_d0", vec[i].name), 32'(wd_log[wr0]), 32'(vec[i].d0));
         end
         if (vec[i].exp_wr >= 2)
            check($sformatf("%s.wr_a1", vec[i].name), 32'(wr_log[wr0+1]), 32'(vec[i].a1));
         if (vec[i].exp_rd >= 1)
            check($sformatf("%s.rd_a0", vec[i].name), 32'(rd_log[rd0]), 32'(vec[i].a0));
         if (vec[i].exp_rd >= 2)
            check($sformatf("%s.rd_a1", vec[i].name), 32'(rd_log[rd0+1]), 32'(vec[i].a1));
      end

      // CS raised after 5 bits of a WRITE data byte: no strobe, WEL stays set.
      spi_xfer(1, 64'h06, got);
      wr0 = wr_cnt;
      @(negedge i_clk);
      spi_cs = 1'b0;
      #HALF;
      spi_bits(8'h02, 8, r);
      spi_bits(8'h00, 8, r);
      spi_bits(8'h00, 8, r);
      spi_bits(8'h20, 8, r);
      spi_bits(8'hFF, 5, r);
      #HALF;
      spi_cs = 1'b1;
      repeat (12) @(negedge i_clk);
      check("partial.n_wr", wr_cnt - wr0, 0);
      spi_xfer(2, 64'h05_00, got);
      check("partial.wel_kept", 32'(got[7:0]), 32'hFE);

      // Asynchronous reset in the middle of a READ data byte.
      @(negedge i_clk);
      spi_cs = 1'b0;
      #HALF;
      spi_bits(8'h03, 8, r);
      spi_bits(8'h00, 8, r);
      spi_bits(8'h00, 8, r);
      spi_bits(8'h10, 8, r);
      spi_bits(8'h00, 3, r);
      #23;
      check("midrd.addr_pre",  32'(ram_addr),  32'h11);
      check("midrd.wdata_pre", 32'(ram_wdata), 32'h22);
      i_rst_n = 1'b0;
      #1;
      check("midrd.miso",  32'(spi_miso),  32'h0);
      check("midrd.addr",  32'(ram_addr),  32'h0);
      check("midrd.rd_en", 32'(ram_rd_en), 32'h0);
      check("midrd.wr_en", 32'(ram_wr_en), 32'h0);
      check("midrd.wdata", 32'(ram_wdata), 32'h0);
      spi_cs = 1'b1;
      spi_mosi = 1'b0;
      repeat (4) @(negedge i_clk);
      i_rst_n = 1'b1;
      repeat (4) @(negedge i_clk);
      spi_xfer(2, 64'h05_00, got);
      check("midrd.status", 32'(got[7:0]), 32'h00);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
